// File: rtl/slc_txreq_link.sv
// CHI link-layer transmitter for the SLC TXREQ channel: link activation FSM,
// L-credit accounting and LCrdReturn generation on deactivation.

package slc_txreq_link_pkg;

  // REQ flit payload as carried on TXREQFLIT.
  typedef struct packed {
    logic [3:0]  qos;
    logic [10:0] tgtid;
    logic [10:0] srcid;
    logic [11:0] txnid;
    logic [10:0] returnnid;
    logic [6:0]  opcode;
    logic [2:0]  size;
    logic [47:0] addr;
    logic        ns;
    logic [1:0]  order;
    logic [3:0]  memattr;
  } reqflit_t;

  localparam logic [6:0] REQ_LCRD_RETURN = 7'h00;

endpackage

module slc_txreq_link
  import slc_txreq_link_pkg::*;
#(
  parameter int unsigned MAX_CRD = 15,
  parameter int unsigned CRD_W   = $clog2(MAX_CRD + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             link_en,
  input  logic             pin_valid,
  output logic             pin_ready,
  input  reqflit_t         txreq_in,
  output logic             txreq_flitpend,
  output logic             txreq_flitv,
  output reqflit_t         txreq_flit,
  input  logic             txreq_lcrdv,
  output logic             txlinkactivereq,
  input  logic             txlinkactiveack,
  output logic             link_run,
  output logic [CRD_W-1:0] crd_cnt,
  output logic             lcrd_err
);

  typedef enum logic [1:0] {
    ST_STOP       = 2'd0,
    ST_ACTIVATE   = 2'd1,
    ST_RUN        = 2'd2,
    ST_DEACTIVATE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CRD_W-1:0] crd_q, crd_d;
  logic             flitv_q, flitv_d;
  reqflit_t         flit_q, flit_d;
  logic             req_q, req_d;
  logic             pend_q, pend_d;
  logic             run_q, run_d;
  logic             err_q, err_d;

  logic             crd_nz;
  logic             crd_full;
  logic             send;
  logic             crd_ret;
  logic             consume;
  reqflit_t         lcrd_flit;

  // Credit status and flit handshake decode from the current state.
  assign crd_nz    = (crd_q != '0);
  assign crd_full  = (crd_q == CRD_W'(MAX_CRD));
  assign pin_ready = (state_q == ST_RUN) && link_en && crd_nz;
  assign send      = pin_valid && pin_ready;
  assign crd_ret   = (state_q == ST_DEACTIVATE) && crd_nz;
  assign consume   = send || crd_ret;

  // LCrdReturn flit: opcode ReqLCrdReturn, every other field zero.
  always_comb begin
    lcrd_flit        = '0;
    lcrd_flit.opcode = REQ_LCRD_RETURN;
  end

  // Next state, credit counter and next values of all registered outputs.
  always_comb begin
    state_d = state_q;
    crd_d   = crd_q;
    err_d   = err_q;
    flitv_d = 1'b0;
    flit_d  = flit_q;

    unique case (state_q)
      ST_STOP: begin
        if (link_en) state_d = ST_ACTIVATE;
      end
      ST_ACTIVATE: begin
        // Mid-handshake abort is not allowed, so link_en is not looked at.
        if (txlinkactiveack) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!link_en) state_d = ST_DEACTIVATE;
      end
      ST_DEACTIVATE: begin
        if (!txlinkactiveack && !crd_nz && !txreq_lcrdv) state_d = ST_STOP;
      end
      default: state_d = ST_STOP;
    endcase

    if (send) begin
      flitv_d = 1'b1;
      flit_d  = txreq_in;
    end else if (crd_ret) begin
      flitv_d = 1'b1;
      flit_d  = lcrd_flit;
    end

    if (txreq_lcrdv) begin
      if (state_q == ST_STOP) begin
        err_d = 1'b1;
      end else if (consume) begin
        crd_d = crd_q;
      end else if (crd_full) begin
        err_d = 1'b1;
      end else begin
        crd_d = crd_q + CRD_W'(1);
      end
    end else if (consume) begin
      crd_d = crd_q - CRD_W'(1);
    end

    req_d  = (state_d == ST_ACTIVATE) || (state_d == ST_RUN);
    pend_d = (state_d == ST_RUN) || (state_d == ST_DEACTIVATE);
    run_d  = (state_d == ST_RUN);
  end

  // State and output registers; reset discards held credits immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_STOP;
      crd_q   <= '0;
      flitv_q <= 1'b0;
      flit_q  <= '0;
      req_q   <= 1'b0;
      pend_q  <= 1'b0;
      run_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      crd_q   <= crd_d;
      flitv_q <= flitv_d;
      flit_q  <= flit_d;
      req_q   <= req_d;
      pend_q  <= pend_d;
      run_q   <= run_d;
      err_q   <= err_d;
    end
  end

  assign txreq_flitpend  = pend_q;
  assign txreq_flitv     = flitv_q;
  assign txreq_flit      = flit_q;
  assign txlinkactivereq = req_q;
  assign link_run        = run_q;
  assign crd_cnt         = crd_q;
  assign lcrd_err        = err_q;

endmodule

// File: tb/tb_slc_txreq_link.sv
// Scoreboard bench for slc_txreq_link: directed bring-up/starvation/
// deactivate/overflow/reset sequences followed by randomized traffic.

module tb_slc_txreq_link;
  import slc_txreq_link_pkg::*;

  localparam int unsigned MAX_CRD = 15;
  localparam int unsigned CRD_W   = $clog2(MAX_CRD + 1);
  localparam int unsigned FW      = $bits(reqflit_t);
  localparam reqflit_t    RET_FLIT = '0;

  typedef enum int {M_STOP, M_ACT, M_RUN, M_DEACT} mstate_e;

  logic             clock;
  logic             reset;
  logic             link_en;
  logic             pin_valid;
  logic             pin_ready;
  reqflit_t         txreq_in;
  logic             txreq_flitpend;
  logic             txreq_flitv;
  reqflit_t         txreq_flit;
  logic             txreq_lcrdv;
  logic             txlinkactivereq;
  logic             txlinkactiveack;
  logic             link_run;
  logic [CRD_W-1:0] crd_cnt;
  logic             lcrd_err;

  slc_txreq_link #(.MAX_CRD(MAX_CRD), .CRD_W(CRD_W)) dut (
    .clock           (clock),
    .reset           (reset),
    .link_en         (link_en),
    .pin_valid       (pin_valid),
    .pin_ready       (pin_ready),
    .txreq_in        (txreq_in),
    .txreq_flitpend  (txreq_flitpend),
    .txreq_flitv     (txreq_flitv),
    .txreq_flit      (txreq_flit),
    .txreq_lcrdv     (txreq_lcrdv),
    .txlinkactivereq (txlinkactivereq),
    .txlinkactiveack (txlinkactiveack),
    .link_run        (link_run),
    .crd_cnt         (crd_cnt),
    .lcrd_err        (lcrd_err)
  );

  int       n_cmp = 0;
  int       n_err = 0;
  reqflit_t exp_q[$];
  reqflit_t mon_last;

  // Reference model state (after the most recent clock edge).
  mstate_e  m_state;
  int       m_crd;
  bit       m_err;
  bit       m_flitv;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic reqflit_t rnd_flit();
    logic [127:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    return reqflit_t'(r[FW-1:0]);
  endfunction

  // One clock cycle: drive inputs at a negedge, predict the edge, check after it.
  task automatic step(input logic le, input logic pv, input reqflit_t f,
                      input logic lv, input logic ack);
    bit rdy, acc, rtn;
    int nxt;
    link_en         = le;
    pin_valid       = pv;
    txreq_in        = f;
    txreq_lcrdv     = lv;
    txlinkactiveack = ack;
    #1;
    rdy = (m_state == M_RUN) && le && (m_crd > 0);
    chk("pin_ready", 128'(pin_ready), 128'(rdy));
    acc = rdy && pv;
    rtn = (m_state == M_DEACT) && (m_crd > 0);
    if (acc) exp_q.push_back(f);
    else if (rtn) exp_q.push_back(RET_FLIT);
    m_flitv = acc || rtn;
    nxt = m_crd - ((acc || rtn) ? 1 : 0);
    if (lv) begin
      if (m_state == M_STOP) m_err = 1'b1;
      else if (nxt + 1 > int'(MAX_CRD)) m_err = 1'b1;
      else nxt = nxt + 1;
    end
    case (m_state)
      M_STOP:  if (le) m_state = M_ACT;
      M_ACT:   if (ack) m_state = M_RUN;
      M_RUN:   if (!le) m_state = M_DEACT;
      M_DEACT: if (!ack && m_crd == 0 && !lv) m_state = M_STOP;
      default: m_state = M_STOP;
    endcase
    m_crd = nxt;
    @(negedge clock);
    chk("txreq_flitv", 128'(txreq_flitv), 128'(m_flitv));
    chk("link_run", 128'(link_run), 128'(m_state == M_RUN));
    chk("txreq_flitpend", 128'(txreq_flitpend), 128'(m_state == M_RUN || m_state == M_DEACT));
    chk("txlinkactivereq", 128'(txlinkactivereq), 128'(m_state == M_ACT || m_state == M_RUN));
    chk("crd_cnt", 128'(crd_cnt), 128'(m_crd));
    chk("lcrd_err", 128'(lcrd_err), 128'(m_err));
  endtask

  task automatic model_reset();
    m_state = M_STOP;
    m_crd   = 0;
    m_err   = 1'b0;
    m_flitv = 1'b0;
    exp_q.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pin_ready"}, 128'(pin_ready), 128'(0));
    chk({tag, "_flitpend"}, 128'(txreq_flitpend), 128'(0));
    chk({tag, "_flitv"}, 128'(txreq_flitv), 128'(0));
    chk({tag, "_flit"}, 128'(txreq_flit), 128'(0));
    chk({tag, "_activereq"}, 128'(txlinkactivereq), 128'(0));
    chk({tag, "_link_run"}, 128'(link_run), 128'(0));
    chk({tag, "_crd_cnt"}, 128'(crd_cnt), 128'(0));
    chk({tag, "_lcrd_err"}, 128'(lcrd_err), 128'(0));
  endtask

  // Monitor: every presented flit must match the head of the expected queue.
  initial begin
    reqflit_t e;
    mon_last = '0;
    forever begin
      @(negedge clock or negedge reset);
      if (!reset) begin
        mon_last = '0;
        continue;
      end
      if (txreq_flitv) begin
        if (exp_q.size() == 0) begin
          chk("flit_unexpected", 128'(1), 128'(0));
        end else begin
          e = exp_q.pop_front();
          chk("txreq_flit", 128'(txreq_flit), 128'(e));
          mon_last = e;
        end
      end else begin
        chk("flit_hold", 128'(txreq_flit), 128'(mon_last));
      end
    end
  end

  // Stimulus.
  initial begin
    reqflit_t z;
    bit le_v, ack_v, lv_v;
    int guard;
    z = '0;
    reset = 1'b0;
    link_en = 1'b0; pin_valid = 1'b0; txreq_in = '0;
    txreq_lcrdv = 1'b0; txlinkactiveack = 1'b0;
    model_reset();
    #3;
    chk_all_zero("reset");
    @(negedge clock);
    @(negedge clock);
    #2 reset = 1'b1;
    @(negedge clock);

    // Bring-up: ack two cycles after req, three credits granted.
    step(1, 0, z, 0, 0);
    step(1, 0, z, 1, 0);
    step(1, 0, z, 1, 1);
    step(1, 0, z, 1, 1);
    chk("bringup_crd", 128'(crd_cnt), 128'(3));
    chk("bringup_run", 128'(link_run), 128'(1));
    chk("bringup_pend", 128'(txreq_flitpend), 128'(1));

    // Starvation: two credits, A and B go, C waits for one more credit.
    step(1, 1, rnd_flit(), 0, 1);
    begin
      reqflit_t fa, fb, fc;
      fa = rnd_flit(); fb = rnd_flit(); fc = rnd_flit();
      step(1, 1, fa, 0, 1);
      step(1, 1, fb, 0, 1);
      step(1, 1, fc, 0, 1);
      step(1, 1, fc, 1, 1);
      step(1, 1, fc, 0, 1);
    end
    chk("starve_crd", 128'(crd_cnt), 128'(0));

    // Simultaneous credit and accept.
    step(1, 0, z, 1, 1);
    step(1, 1, rnd_flit(), 1, 1);
    chk("simul_crd", 128'(crd_cnt), 128'(1));
    chk("simul_flitv", 128'(txreq_flitv), 128'(1));

    // Deactivate with four credits held.
    for (int i = 0; i < 3; i++) step(1, 0, z, 1, 1);
    step(0, 0, z, 0, 1);
    chk("deact_req", 128'(txlinkactivereq), 128'(0));
    for (int i = 0; i < 4; i++) step(0, 0, z, 0, 1);
    chk("deact_crd", 128'(crd_cnt), 128'(0));
    step(0, 0, z, 0, 0);
    chk("deact_pend", 128'(txreq_flitpend), 128'(0));

    // Overflow: sixteen credits into a fifteen-credit counter.
    step(1, 0, z, 0, 0);
    step(1, 0, z, 0, 1);
    for (int i = 0; i < 16; i++) step(1, 0, z, 1, 1);
    chk("ovf_crd", 128'(crd_cnt), 128'(15));
    chk("ovf_err", 128'(lcrd_err), 128'(1));
    step(1, 0, z, 0, 1);
    chk("ovf_err_sticky", 128'(lcrd_err), 128'(1));

    // Drop to five credits with a flit on the wire, then reset asynchronously.
    for (int i = 0; i < 10; i++) step(1, 1, rnd_flit(), 0, 1);
    chk("prerst_crd", 128'(crd_cnt), 128'(5));
    chk("prerst_flitv", 128'(txreq_flitv), 128'(1));
    #2;
    reset = 1'b0;
    link_en = 1'b0; pin_valid = 1'b0; txreq_lcrdv = 1'b0; txlinkactiveack = 1'b0;
    #1;
    chk_all_zero("midrst");
    model_reset();
    #1 reset = 1'b1;
    @(negedge clock);

    // Randomized traffic against the model.
    le_v = 1'b0;
    ack_v = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 19) == 0) le_v = ~le_v;
      if ((m_state == M_ACT || m_state == M_RUN) && !ack_v && $urandom_range(0, 2) == 0)
        ack_v = 1'b1;
      else if (!(m_state == M_ACT || m_state == M_RUN) && ack_v && $urandom_range(0, 2) == 0)
        ack_v = 1'b0;
      if (m_state == M_STOP) lv_v = ($urandom_range(0, 199) == 0);
      else lv_v = ($urandom_range(0, 3) == 0);
      step(le_v, 1'($urandom_range(0, 1)), rnd_flit(), lv_v, ack_v);
    end

    // Drain back to STOP and make sure nothing is left outstanding.
    guard = 0;
    while (m_state != M_STOP && guard < 200) begin
      if (!(m_state == M_ACT || m_state == M_RUN)) ack_v = 1'b0;
      step(1'b0, 1'b0, z, 1'b0, ack_v);
      guard++;
    end
    chk("drain_stop", 128'(m_state == M_STOP), 128'(1));
    step(1'b0, 1'b0, z, 1'b0, 1'b0);
    chk("drain_queue", 128'(exp_q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/slc_txreq_link.md
Name: slc_txreq_link

Overview:
- CHI link-layer transmitter for the SLC TXREQ channel.
- Sits directly downstream of the TXREQ pipe stage: consumes its valid/ready flit stream and drives TXREQFLITV/TXREQFLIT onto the interconnect.
- Owns the TX link-activation state machine (TXLINKACTIVEREQ/ACK) and L-credit accounting.
- Returns all held credits with LCrdReturn flits on deactivation.

Parameters:
- MAX_CRD, 15, maximum L-credits the receiver may grant (CHI limit 15).
- CRD_W, $clog2(MAX_CRD+1), width of credit counter.

Ports:
- clock  input  1  single clock.
- reset  input  1  asynchronous, active-low reset.
- link_en  input  1  request the TX link to be active.
- pin_valid  input  1  flit available from the upstream pipe.
- pin_ready  output  1  flit accepted this cycle.
- txreq_in  input  $bits(reqflit_t)  flit from the upstream pipe.
- txreq_flitpend  output  1  CHI TXREQFLITPEND.
- txreq_flitv  output  1  CHI TXREQFLITV.
- txreq_flit  output  $bits(reqflit_t)  CHI TXREQFLIT.
- txreq_lcrdv  input  1  CHI TXREQLCRDV, one credit per cycle high.
- txlinkactivereq  output  1  CHI TXLINKACTIVEREQ.
- txlinkactiveack  input  1  CHI TXLINKACTIVEACK.
- link_run  output  1  status: state==RUN.
- crd_cnt  output  CRD_W  current credit count.
- lcrd_err  output  1  sticky: credit received while crd_cnt==MAX_CRD.

Behaviour:
- Reset (reset=0, async): state=STOP, crd_cnt=0, txreq_flitv=0, txreq_flit=0, txlinkactivereq=0, lcrd_err=0. All outputs are 0 during reset.
- States and transitions:
  - STOP: txlinkactivereq=0. link_en=1 -> ACTIVATE.
  - ACTIVATE: txlinkactivereq=1. txlinkactiveack=1 -> RUN. link_en is ignored in ACTIVATE; CHI forbids aborting mid-handshake.
  - RUN: txlinkactivereq=1. link_en=0 -> DEACTIVATE.
  - DEACTIVATE: txlinkactivereq=0. Return credits. Exit to STOP when txlinkactiveack=0 and crd_cnt=0 and no lcrdv in the same cycle.
- Outputs are registered; state-driven outputs change the cycle after the transition condition is sampled.
- pin_ready = (state==RUN) && link_en && (crd_cnt!=0). This is combinational; it does not depend on pin_valid.
- Send: when pin_valid && pin_ready, the next cycle has txreq_flitv=1 and txreq_flit=txreq_in (1-cycle latency), and one credit is consumed.
- When no send or credit-return occurs: txreq_flitv=0 and txreq_flit holds its last value.
- txreq_flitpend = 1 in RUN and DEACTIVATE (registered with state), 0 otherwise. It therefore precedes any flitv by at least one cycle.
- Credit return:
  - In DEACTIVATE with crd_cnt!=0, emit one LCrdReturn flit per cycle: txreq_flitv=1, txreq_flit all-zero (opcode ReqLCrdReturn=0, all other fields 0).
  - Each return decrements crd_cnt.
- Credit counter:
  - txreq_lcrdv increments crd_cnt in ACTIVATE, RUN and DEACTIVATE. In STOP it is ignored and sets lcrd_err.
  - Increment and consume in the same cycle -> crd_cnt unchanged.
  - lcrdv while crd_cnt==MAX_CRD with no same-cycle consume -> no increment, lcrd_err=1 (sticky until reset).
- link_en falling in the same cycle as an accepted flit: the flit is still sent next cycle, then DEACTIVATE begins returning the remaining credits.
- Reset asserted mid-operation: immediate return to STOP. Held credits are discarded; no flit is emitted.

Test Plan:
- Bring-up: link_en=1, ack raised 2 cycles after req, receiver sends 3 lcrdv -> state RUN, crd_cnt=3, link_run=1, flitpend=1.
- Credit starvation: crd_cnt=2, pin_valid held high with flits A,B,C -> A and B on txreq_flitv on consecutive cycles, pin_ready=0 for C. One lcrdv -> C sent on the following cycle, crd_cnt=0.
- Simultaneous: crd_cnt=1, lcrdv and accept in the same cycle -> crd_cnt stays 1, flit emitted.
- Deactivate: crd_cnt=4, link_en=0 -> txlinkactivereq=0, four consecutive all-zero flits with flitv=1, crd_cnt reaches 0. Ack dropped -> STOP, flitpend=0.
- Overflow: 16 lcrdv pulses with MAX_CRD=15 -> crd_cnt=15, lcrd_err=1 and stays 1.
- Async reset in RUN with crd_cnt=5 and flitv=1 -> all outputs 0 immediately, state STOP, crd_cnt=0.
